// File: rtl/spi_regfile_pkg.sv
// Shared types and helpers for the SPI register-file peripheral.
// Contents:
//   state_t         - frame FSM states (IDLE, ADDR, DATA, DONE)
//   RW_WRITE        - value of the leading frame bit that marks a write
//   frame_len()     - total bits in one frame: R/W + address + data
//   sample_on_rise() - 1 when the data sample edge is the rising sclk edge
package spi_regfile_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    DONE
  } state_t;

  localparam logic RW_WRITE = 1'b1;

  function automatic int frame_len(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

  // Modes 0 and 3 sample on the rising edge, modes 1 and 2 on the falling edge.
  function automatic bit sample_on_rise(input int cpol, input int cpha);
    return (cpol == cpha);
  endfunction

endpackage

// File: rtl/spi_sclk_edges.sv
// Brings the asynchronous SPI pins into the clk domain and turns sclk
// transitions into single-cycle sample/launch strobes.
// Ports:
//   clk, rst_n         - system clock, asynchronous active-low reset
//   sclk, ncs, copi    - raw SPI pins (asynchronous)
//   ncs_s, copi_s      - synchronised chip select and data
//   sample_pulse       - 1-clk pulse on each detected sample edge
//   launch_pulse       - 1-clk pulse on each detected launch edge
module spi_sclk_edges #(
  parameter int SYNC_LEN    = 2,
  parameter bit IDLE_LVL    = 1'b0,
  parameter bit SAMPLE_RISE = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sclk,
  input  logic ncs,
  input  logic copi,
  output logic ncs_s,
  output logic copi_s,
  output logic sample_pulse,
  output logic launch_pulse
);

  logic [SYNC_LEN-1:0] sclk_sync;
  logic [SYNC_LEN-1:0] ncs_sync;
  logic [SYNC_LEN-1:0] copi_sync;
  logic                sclk_d;
  logic                sclk_s;
  logic                rise;
  logic                fall;

  // sclk resets to its idle level and ncs to deasserted so that leaving
  // reset never fabricates an edge or a frame start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= {SYNC_LEN{IDLE_LVL}};
      ncs_sync  <= {SYNC_LEN{1'b1}};
      copi_sync <= '0;
      sclk_d    <= IDLE_LVL;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_LEN-2:0], sclk};
      ncs_sync  <= {ncs_sync[SYNC_LEN-2:0], ncs};
      copi_sync <= {copi_sync[SYNC_LEN-2:0], copi};
      sclk_d    <= sclk_s;
    end
  end

  assign sclk_s = sclk_sync[SYNC_LEN-1];
  assign ncs_s  = ncs_sync[SYNC_LEN-1];
  assign copi_s = copi_sync[SYNC_LEN-1];

  assign rise = sclk_s & ~sclk_d;
  assign fall = ~sclk_s & sclk_d;

  assign sample_pulse = SAMPLE_RISE ? rise : fall;
  assign launch_pulse = SAMPLE_RISE ? fall : rise;

endmodule

// File: rtl/spi_regfile_periph.sv
// SPI register-file peripheral with read-back. Each frame is R/W, address,
// then data, MSB first. Writes land in NUM_REGS registers of DATA_W bits;
// reads stream the addressed register out on cipo during the data phase.
// Ports:
//   clk, rst_n   - system clock, asynchronous active-low reset
//   sclk, ncs, copi - SPI pins from the controller (asynchronous)
//   cipo, cipo_oe   - peripheral data out and its pad output enable
//   regs_flat    - all registers, reg i at [i*DATA_W +: DATA_W]
//   wr_strobe    - 1-clk pulse on every committed write
//   wr_addr      - address of the last committed write
module spi_regfile_periph
  import spi_regfile_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 7,
  parameter int NUM_REGS = 5,
  parameter int SYNC_LEN = 2,
  parameter int CPOL     = 0,
  parameter int CPHA     = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       sclk,
  input  logic                       ncs,
  input  logic                       copi,
  output logic                       cipo,
  output logic                       cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0] regs_flat,
  output logic                       wr_strobe,
  output logic [ADDR_W-1:0]          wr_addr
);

  localparam int F     = frame_len(ADDR_W, DATA_W);
  localparam int CNT_W = $clog2(F + 1);
  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic              ncs_s;
  logic              copi_s;
  logic              sample_pulse;
  logic              launch_pulse;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W:0]   hdr;
  logic [DATA_W-1:0] data_sh;
  logic [DATA_W-1:0] out_shift;
  logic              frame_done;
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [DATA_W-1:0] rd_data;

  spi_sclk_edges #(
    .SYNC_LEN   (SYNC_LEN),
    .IDLE_LVL   (CPOL != 0),
    .SAMPLE_RISE(sample_on_rise(CPOL, CPHA))
  ) u_edges (
    .clk         (clk),
    .rst_n       (rst_n),
    .sclk        (sclk),
    .ncs         (ncs),
    .copi        (copi),
    .ncs_s       (ncs_s),
    .copi_s      (copi_s),
    .sample_pulse(sample_pulse),
    .launch_pulse(launch_pulse)
  );

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < (ADDR_W + 1)'(NUM_REGS));
  endfunction

  // Out-of-range addresses read back as zero.
  always_comb begin
    rd_data = '0;
    if (in_range(hdr[ADDR_W-1:0])) rd_data = regs[hdr[IDX_W-1:0]];
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
    assign regs_flat[i*DATA_W +: DATA_W] = regs[i];
  end

  // The header and data shifters are kept apart so the R/W flag and address
  // stay put while the data phase shifts. The write commits the cycle after
  // the final sample (frame_done), and does so even if ncs rises in that
  // same cycle, because the frame was already complete. A deasserted ncs
  // outranks any coincident sclk edge, so aborts always discard the frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      hdr        <= '0;
      data_sh    <= '0;
      out_shift  <= '0;
      frame_done <= 1'b0;
      cipo       <= 1'b0;
      cipo_oe    <= 1'b0;
      wr_strobe  <= 1'b0;
      wr_addr    <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      wr_strobe  <= 1'b0;
      frame_done <= 1'b0;
      cipo_oe    <= ~ncs_s;

      if (frame_done && hdr[ADDR_W] == RW_WRITE && in_range(hdr[ADDR_W-1:0])) begin
        regs[hdr[IDX_W-1:0]] <= data_sh;
        wr_strobe            <= 1'b1;
        wr_addr              <= hdr[ADDR_W-1:0];
      end

      if (ncs_s) begin
        state <= IDLE;
        cnt   <= '0;
        cipo  <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            state <= ADDR;
            cnt   <= '0;
            hdr   <= '0;
          end
          ADDR: begin
            cipo <= 1'b0;
            if (sample_pulse) begin
              hdr <= {hdr[ADDR_W-1:0], copi_s};
              cnt <= cnt + 1'b1;
              if (cnt == CNT_W'(ADDR_W)) state <= DATA;
            end
          end
          DATA: begin
            if (sample_pulse) begin
              data_sh <= {data_sh[DATA_W-2:0], copi_s};
              cnt     <= cnt + 1'b1;
              if (cnt == CNT_W'(F - 1)) begin
                state      <= DONE;
                frame_done <= 1'b1;
              end
            end else if (launch_pulse && hdr[ADDR_W] != RW_WRITE) begin
              // First launch of the data phase snapshots the register, so a
              // write later in the same frame cannot affect what is read.
              if (cnt == CNT_W'(ADDR_W + 1)) begin
                out_shift <= rd_data;
                cipo      <= rd_data[DATA_W-1];
              end else begin
                out_shift <= out_shift << 1;
                cipo      <= out_shift[DATA_W-2];
              end
            end
          end
          DONE: begin
            cipo <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
